// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU select codes,
// state encodings and the EXEC-stage ALU decode used by the control FSM.
package cpu_control_fsm_pkg;

    localparam int unsigned IW  = 18;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OpAdd  = 4'h0;
    localparam logic [OPW-1:0] OpAddi = 4'h1;
    localparam logic [OPW-1:0] OpAnd  = 4'h2;
    localparam logic [OPW-1:0] OpAndi = 4'h3;
    localparam logic [OPW-1:0] OpNand = 4'h4;
    localparam logic [OPW-1:0] OpNor  = 4'h5;
    localparam logic [OPW-1:0] OpLd   = 4'h6;
    localparam logic [OPW-1:0] OpSt   = 4'h7;
    localparam logic [OPW-1:0] OpCmp  = 4'h8;
    localparam logic [OPW-1:0] OpJump = 4'h9;
    localparam logic [OPW-1:0] OpJe   = 4'hA;
    localparam logic [OPW-1:0] OpJa   = 4'hB;
    localparam logic [OPW-1:0] OpJb   = 4'hC;
    localparam logic [OPW-1:0] OpJae  = 4'hD;
    localparam logic [OPW-1:0] OpJbe  = 4'hE;
    localparam logic [OPW-1:0] OpIll  = 4'hF;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluAnd  = 3'b001;
    localparam logic [2:0] AluNand = 3'b010;
    localparam logic [2:0] AluNor  = 3'b011;
    localparam logic [2:0] AluSub  = 3'b100;
    localparam logic [2:0] AluAddi = 3'b101;
    localparam logic [2:0] AluAndi = 3'b110;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    // LD/ST reuse the ADDI path to form base + imm6.
    function automatic logic [2:0] alu_sel(input logic [OPW-1:0] op);
        case (op)
            OpAnd:        return AluAnd;
            OpNand:       return AluNand;
            OpNor:        return AluNor;
            OpCmp:        return AluSub;
            OpAddi:       return AluAddi;
            OpLd, OpSt:   return AluAddi;
            OpAndi:       return AluAndi;
            default:      return AluAdd;
        endcase
    endfunction

    function automatic logic uses_imm(input logic [OPW-1:0] op);
        return (op == OpAddi) || (op == OpAndi) || (op == OpLd) || (op == OpSt);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control-unit to datapath bundle: IR/handshake/flag inputs and all control strobes.
interface cpu_control_fsm_if;
    import cpu_control_fsm_pkg::*;

    logic [IW-1:0] instr;
    logic          mem_ready;
    logic          zf_in;
    logic          cf_in;
    logic [2:0]    alu_control;
    logic          alu_src_imm;
    logic          imem_read;
    logic          ir_write;
    logic          pc_inc;
    logic          pc_load;
    logic          dmem_read;
    logic          dmem_write;
    logic          mem_to_reg;
    logic          reg_write;
    logic          flag_write;
    logic          zf;
    logic          cf;
    logic [2:0]    state;

    modport master (
        input  instr, mem_ready, zf_in, cf_in,
        output alu_control, alu_src_imm, imem_read, ir_write, pc_inc, pc_load,
               dmem_read, dmem_write, mem_to_reg, reg_write, flag_write, zf, cf, state
    );

    modport slave (
        output instr, mem_ready, zf_in, cf_in,
        input  alu_control, alu_src_imm, imem_read, ir_write, pc_inc, pc_load,
               dmem_read, dmem_write, mem_to_reg, reg_write, flag_write, zf, cf, state
    );

endinterface

// File: rtl/cpu_control_fsm_branch_eval.sv
// Conditional-branch resolution from opcode and architectural flags.
module cpu_control_fsm_branch_eval
    import cpu_control_fsm_pkg::*;
(
    input  logic [OPW-1:0] i_opcode,
    input  logic           i_zf,
    input  logic           i_cf,
    output logic           o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_opcode)
            OpJe:    o_taken = i_zf;
            OpJa:    o_taken = !i_zf && !i_cf;
            OpJb:    o_taken = i_cf;
            OpJae:   o_taken = !i_cf;
            OpJbe:   o_taken = i_cf || i_zf;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 18-bit datapath; owns ZF/CF.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    cpu_control_fsm_if.master  bus
);

    state_e         r_state;
    state_e         w_state_next;
    logic           r_zf;
    logic           r_cf;
    logic [OPW-1:0] w_opcode;
    logic           w_taken;
    logic           w_unused_instr;

    logic [2:0] w_alu_control;
    logic       w_alu_src_imm;
    logic       w_imem_read;
    logic       w_ir_write;
    logic       w_pc_inc;
    logic       w_pc_load;
    logic       w_dmem_read;
    logic       w_dmem_write;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_flag_write;

    assign w_opcode       = bus.instr[IW-1 -: OPW];
    assign w_unused_instr = ^bus.instr[IW-OPW-1:0];

    cpu_control_fsm_branch_eval u_branch_eval (
        .i_opcode (w_opcode),
        .i_zf     (r_zf),
        .i_cf     (r_cf),
        .o_taken  (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zf <= 1'b0;
            r_cf <= 1'b0;
        end else if (w_flag_write) begin
            r_zf <= bus.zf_in;
            r_cf <= bus.cf_in;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_alu_control = AluAdd;
        w_alu_src_imm = 1'b0;
        w_imem_read   = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_dmem_read   = 1'b0;
        w_dmem_write  = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_flag_write  = 1'b0;

        case (r_state)
            StFetch: begin
                w_imem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_inc     = 1'b1;
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (w_opcode == OpJump) begin
                    w_pc_load    = 1'b1;
                    w_state_next = StFetch;
                end else if (w_opcode == OpIll) begin
                    w_state_next = StFetch;
                end else begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_alu_control = alu_sel(w_opcode);
                w_alu_src_imm = uses_imm(w_opcode);
                case (w_opcode)
                    OpAdd, OpAddi, OpAnd, OpAndi, OpNand, OpNor: w_state_next = StWb;
                    OpLd, OpSt:                                  w_state_next = StMem;
                    OpCmp: begin
                        w_flag_write = 1'b1;
                        w_state_next = StFetch;
                    end
                    OpJe, OpJa, OpJb, OpJae, OpJbe: begin
                        w_pc_load    = w_taken;
                        w_state_next = StFetch;
                    end
                    default:                                     w_state_next = StFetch;
                endcase
            end
            StMem: begin
                // Address operands held so the effective address is stable across stalls.
                w_alu_control = AluAddi;
                w_alu_src_imm = 1'b1;
                if (w_opcode == OpLd) begin
                    w_dmem_read = 1'b1;
                    if (bus.mem_ready) w_state_next = StWb;
                end else if (w_opcode == OpSt) begin
                    w_dmem_write = 1'b1;
                    if (bus.mem_ready) w_state_next = StFetch;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StWb: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (w_opcode == OpLd);
                w_state_next = StFetch;
            end
            default: w_state_next = StFetch;
        endcase
    end

    // Reset forces every strobe low immediately, without waiting for a clock edge.
    assign bus.alu_control = w_alu_control & {3{rst_n}};
    assign bus.alu_src_imm = w_alu_src_imm & rst_n;
    assign bus.imem_read   = w_imem_read & rst_n;
    assign bus.ir_write    = w_ir_write & rst_n;
    assign bus.pc_inc      = w_pc_inc & rst_n;
    assign bus.pc_load     = w_pc_load & rst_n;
    assign bus.dmem_read   = w_dmem_read & rst_n;
    assign bus.dmem_write  = w_dmem_write & rst_n;
    assign bus.mem_to_reg  = w_mem_to_reg & rst_n;
    assign bus.reg_write   = w_reg_write & rst_n;
    assign bus.flag_write  = w_flag_write & rst_n;
    assign bus.zf          = r_zf;
    assign bus.cf          = r_cf;
    assign bus.state       = r_state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: per-cycle state and control-strobe checks.
module tb_cpu_control_fsm;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed strobes: {alu[2:0], imm, imem, irw, pci, pcl, dr, dw, m2r, rw, fw}
    localparam logic [12:0] IMM  = 13'h200;
    localparam logic [12:0] IMEM = 13'h100;
    localparam logic [12:0] IRW  = 13'h080;
    localparam logic [12:0] PCI  = 13'h040;
    localparam logic [12:0] PCL  = 13'h020;
    localparam logic [12:0] DR   = 13'h010;
    localparam logic [12:0] DW   = 13'h008;
    localparam logic [12:0] M2R  = 13'h004;
    localparam logic [12:0] RW   = 13'h002;
    localparam logic [12:0] FW   = 13'h001;
    localparam logic [12:0] FOK  = IMEM | IRW | PCI;

    localparam logic [17:0] I_ADD  = 18'h00000;
    localparam logic [17:0] I_LD   = 18'h18000;
    localparam logic [17:0] I_ST   = 18'h1C000;
    localparam logic [17:0] I_CMP  = 18'h20000;
    localparam logic [17:0] I_JUMP = 18'h24000;
    localparam logic [17:0] I_JE   = 18'h28000;
    localparam logic [17:0] I_JA   = 18'h2C000;
    localparam logic [17:0] I_JB   = 18'h30000;
    localparam logic [17:0] I_JAE  = 18'h34000;
    localparam logic [17:0] I_JBE  = 18'h38000;
    localparam logic [17:0] I_ILL  = 18'h3C000;

    logic [12:0] ctl_obs;
    assign ctl_obs = {bus.alu_control, bus.alu_src_imm, bus.imem_read, bus.ir_write, bus.pc_inc,
                      bus.pc_load, bus.dmem_read, bus.dmem_write, bus.mem_to_reg, bus.reg_write,
                      bus.flag_write};

    function automatic logic [12:0] alu(input logic [2:0] c);
        return {c, 10'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check state and strobes in the current cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [12:0] ctl);
        #1;
        chk({tag, ".state"}, 32'(bus.state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl_obs), 32'(ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic ezf, input logic ecf);
        chk({tag, ".zf"}, 32'(bus.zf), 32'(ezf));
        chk({tag, ".cf"}, 32'(bus.cf), 32'(ecf));
    endtask

    task automatic branch(input string tag, input logic [17:0] ins, input logic taken);
        bus.instr = ins;
        cyc({tag, ".F"}, 3'd0, FOK);
        cyc({tag, ".D"}, 3'd1, '0);
        cyc({tag, ".E"}, 3'd2, taken ? PCL : 13'h0);
    endtask

    task automatic cmp(input string tag, input logic zin, input logic cin);
        bus.instr = I_CMP;
        bus.zf_in = zin;
        bus.cf_in = cin;
        cyc({tag, ".F"}, 3'd0, FOK);
        cyc({tag, ".D"}, 3'd1, '0);
        cyc({tag, ".E"}, 3'd2, alu(3'b100) | FW);
        flags(tag, zin, cin);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.instr     = I_ADD;
        bus.mem_ready = 1'b0;
        bus.zf_in     = 1'b0;
        bus.cf_in     = 1'b0;

        #2;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.ctl", 32'(ctl_obs), 32'd0);
        flags("rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD: 4 cycles, reg_write only in WB.
        bus.mem_ready = 1'b1;
        cyc("add.F", 3'd0, FOK);
        cyc("add.D", 3'd1, '0);
        cyc("add.E", 3'd2, alu(3'b000));
        cyc("add.W", 3'd4, RW);

        // Flag writes and branch resolution on the registered flags.
        cmp("cmp00", 1'b0, 1'b0);
        branch("ja_t", I_JA, 1'b1);
        cmp("cmp10", 1'b1, 1'b0);
        bus.zf_in = 1'b0;
        bus.cf_in = 1'b1;
        branch("je_t", I_JE, 1'b1);
        branch("jb_n", I_JB, 1'b0);
        branch("jae_t", I_JAE, 1'b1);
        branch("jbe_t", I_JBE, 1'b1);
        flags("nochg", 1'b1, 1'b0);
        cmp("cmp01", 1'b0, 1'b1);
        branch("jb_t", I_JB, 1'b1);
        branch("jae_n", I_JAE, 1'b0);
        branch("je_n", I_JE, 1'b0);
        cmp("cmp11", 1'b1, 1'b1);
        branch("ja_n", I_JA, 1'b0);

        // LD with three stall cycles in MEM: 8 cycles total.
        bus.instr = I_LD;
        cyc("ld.F", 3'd0, FOK);
        cyc("ld.D", 3'd1, '0);
        cyc("ld.E", 3'd2, alu(3'b101) | IMM);
        bus.mem_ready = 1'b0;
        cyc("ld.M0", 3'd3, alu(3'b101) | IMM | DR);
        cyc("ld.M1", 3'd3, alu(3'b101) | IMM | DR);
        cyc("ld.M2", 3'd3, alu(3'b101) | IMM | DR);
        bus.mem_ready = 1'b1;
        cyc("ld.M3", 3'd3, alu(3'b101) | IMM | DR);
        cyc("ld.W", 3'd4, RW | M2R);

        // ST interrupted by asynchronous reset in MEM.
        bus.instr = I_ST;
        cyc("st.F", 3'd0, FOK);
        cyc("st.D", 3'd1, '0);
        cyc("st.E", 3'd2, alu(3'b101) | IMM);
        bus.mem_ready = 1'b0;
        cyc("st.M0", 3'd3, alu(3'b101) | IMM | DW);
        #1;
        chk("st.M1.ctl", 32'(ctl_obs), 32'(alu(3'b101) | IMM | DW));
        #2;
        rst_n = 1'b0;
        #1;
        chk("st.rst.dw", 32'(bus.dmem_write), 32'd0);
        chk("st.rst.ctl", 32'(ctl_obs), 32'd0);
        chk("st.rst.state", 32'(bus.state), 32'd0);
        flags("st.rst", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("st.rsthold.ctl", 32'(ctl_obs), 32'd0);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        flags("st.rel", 1'b0, 1'b0);

        // Illegal opcode then JUMP.
        bus.instr = I_ILL;
        cyc("ill.F", 3'd0, FOK);
        cyc("ill.D", 3'd1, '0);
        bus.instr = I_JUMP;
        cyc("jmp.F", 3'd0, FOK);
        cyc("jmp.D", 3'd1, PCL);

        // Fetch stall: strobes only in the ready cycle.
        bus.instr = I_ADD;
        bus.mem_ready = 1'b0;
        cyc("fs.F0", 3'd0, IMEM);
        cyc("fs.F1", 3'd0, IMEM);
        bus.mem_ready = 1'b1;
        cyc("fs.F2", 3'd0, FOK);
        cyc("fs.D", 3'd1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
